// File: rtl/vote_collector_pkg.sv
// -----------------------------------------------------------------------------
// vote_collector_pkg
//   Shared definitions for the ballot-collection front end of the three-voter
//   majority unit: FSM state encoding, voter bit positions and the per-voter
//   lock/ballot update rule.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package vote_collector_pkg;

  // Binary encoding is fixed so that 2'b11 is the single illegal code.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OPEN = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Voter bit positions inside every 3-bit voter vector.
  localparam int V_A        = 0;
  localparam int V_B        = 1;
  localparam int V_C        = 2;
  localparam int NUM_VOTERS = 3;

  // One voter's lock/ballot update for a cycle in which the window is open.
  // A voter that is already locked keeps both flag and ballot. A lone yes
  // edge locks a 1, a lone no edge locks a 0. Simultaneous yes and no edges
  // are ambiguous and leave the voter unlocked.
  typedef struct packed {
    logic locked;
    logic ballot;
  } voter_t;

  function automatic voter_t voter_update(input voter_t cur,
                                          input logic   yes_edge,
                                          input logic   no_edge);
    voter_t nxt;
    nxt = cur;
    if (!cur.locked && (yes_edge ^ no_edge)) begin
      nxt.locked = 1'b1;
      nxt.ballot = yes_edge;
    end
    return nxt;
  endfunction

endpackage : vote_collector_pkg

// File: rtl/vote_edge_sync.sv
// -----------------------------------------------------------------------------
// vote_edge_sync
//   Brings WIDTH raw, asynchronous push-button levels into the clk domain
//   with a two-flop synchroniser, delays them by one further flop and flags
//   the rising edge. A button held high produces exactly one edge; it must be
//   released and pressed again to produce another.
//
// Ports
//   clk    in   1       rising-edge clock
//   reset  in   1       asynchronous, active-high; clears all stages
//   din    in   WIDTH   raw button levels (asynchronous to clk)
//   rise   out  WIDTH   one-cycle pulse per synchronised rising edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vote_edge_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1;  // metastability catch
  logic [WIDTH-1:0] s2;  // synchronised level
  logic [WIDTH-1:0] s3;  // previous synchronised level

  // NOTE: every flop here is clocked state, so it is written with <=; a
  // blocking '=' would let s2 see this cycle's s1 and collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule : vote_edge_sync

// File: rtl/vote_collector.sv
// -----------------------------------------------------------------------------
// vote_collector
//   Upstream stage of the three-voter majority unit (chair A holds the veto;
//   downstream computes pass = A & (B | C)). Synchronises the six raw yes/no
//   buttons, opens a timed ballot window on start, locks each voter's first
//   unambiguous choice and closes early once all three have voted. The locked
//   ballots are then held, with a valid flag, until the next start.
//
// Parameters
//   WINDOW_CYCLES  window length in clk cycles, counted from the first OPEN
//                  cycle; must be >= 2
//   CNT_W          timer width; 2**CNT_W must exceed WINDOW_CYCLES
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-high
//   start          in   1      opens a new ballot window (IDLE or HOLD only)
//   yes_btn        in   3      raw yes buttons, bit0=A bit1=B bit2=C
//   no_btn         in   3      raw no buttons, same mapping
//   A, B, C        out  1      registered ballots (1 = yes); 0 unless valid
//   ballots_valid  out  1      high while holding a completed ballot set
//   done           out  1      one-cycle pulse as the window closes
//   voted          out  3      per-voter lock flags for the current window
//   busy           out  1      high while the window is open
//   time_left      out  CNT_W  remaining window cycles; 0 outside the window
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vote_collector
  import vote_collector_pkg::*;
#(
  parameter int WINDOW_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       yes_btn,
  input  logic [2:0]       no_btn,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             ballots_valid,
  output logic             done,
  output logic [2:0]       voted,
  output logic             busy,
  output logic [CNT_W-1:0] time_left
);

  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Button synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic [5:0] btn_rise;
  logic [2:0] yes_rise;
  logic [2:0] no_rise;

  vote_edge_sync #(
    .WIDTH (6)
  ) u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({no_btn, yes_btn}),
    .rise  (btn_rise)
  );

  assign yes_rise = btn_rise[2:0];
  assign no_rise  = btn_rise[5:3];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state,     state_nxt;
  logic [2:0]       ballot,    ballot_nxt;
  logic [2:0]       voted_nxt;
  logic [CNT_W-1:0] timer_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ballot    <= '0;
      voted     <= '0;
      time_left <= '0;
    end else begin
      state     <= state_nxt;
      ballot    <= ballot_nxt;
      voted     <= voted_nxt;
      time_left <= timer_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, vote locking and window timer
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned below gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    voter_t v;
    state_nxt  = state;
    ballot_nxt = ballot;
    voted_nxt  = voted;
    timer_nxt  = time_left;
    v          = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_OPEN;
          ballot_nxt = '0;
          voted_nxt  = '0;
          timer_nxt  = WIN_LOAD;
        end
      end

      S_OPEN: begin
        // start is deliberately ignored here: a window cannot be restarted.
        for (int i = 0; i < NUM_VOTERS; i++) begin
          v             = voter_update('{locked: voted[i], ballot: ballot[i]},
                                       yes_rise[i], no_rise[i]);
          voted_nxt[i]  = v.locked;
          ballot_nxt[i] = v.ballot;
        end
        // Votes landing on the last cycle are already in voted_nxt, so they
        // are counted before the window closes.
        if (voted_nxt == 3'b111 || time_left == WIN_LAST) begin
          state_nxt = S_HOLD;
          timer_nxt = '0;
        end else begin
          timer_nxt = time_left - WIN_LAST;
        end
      end

      S_HOLD: begin
        if (start) begin
          state_nxt  = S_OPEN;
          ballot_nxt = '0;
          voted_nxt  = '0;
          timer_nxt  = WIN_LOAD;
        end
      end

      default: begin
        // Illegal encoding: recover to a clean IDLE on the next edge.
        state_nxt  = S_IDLE;
        ballot_nxt = '0;
        voted_nxt  = '0;
        timer_nxt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  //   Derived from next-state values so they line up with the state register
  //   while still being flops (no combinational input-to-output path).
  //   Unvoted voters are already 0 in ballot_nxt, so abstain counts as no.
  // ---------------------------------------------------------------------------
  logic hold_nxt;
  assign hold_nxt = (state_nxt == S_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A             <= 1'b0;
      B             <= 1'b0;
      C             <= 1'b0;
      ballots_valid <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      A             <= hold_nxt & ballot_nxt[V_A];
      B             <= hold_nxt & ballot_nxt[V_B];
      C             <= hold_nxt & ballot_nxt[V_C];
      ballots_valid <= hold_nxt;
      done          <= hold_nxt && (state != S_HOLD);
      busy          <= (state_nxt == S_OPEN);
    end
  end

endmodule : vote_collector

// File: tb/tb_vote_collector.sv
// -----------------------------------------------------------------------------
// tb_vote_collector
//   Directed bench for vote_collector with WINDOW_CYCLES=16. Inputs are
//   driven 1 ns after a rising edge and outputs are sampled at the same point.
//   A button pulse set at window cycle k produces an edge during cycle k+2 and
//   shows in voted from cycle k+3 on.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vote_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] yes_btn;
  logic [2:0] no_btn;
  logic       A, B, C;
  logic       ballots_valid;
  logic       done;
  logic [2:0] voted;
  logic       busy;
  logic [4:0] time_left;

  int n_checks = 0;
  int n_fail   = 0;

  vote_collector #(
    .WINDOW_CYCLES (16),
    .CNT_W         (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .yes_btn       (yes_btn),
    .no_btn        (no_btn),
    .A             (A),
    .B             (B),
    .C             (C),
    .ballots_valid (ballots_valid),
    .done          (done),
    .voted         (voted),
    .busy          (busy),
    .time_left     (time_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle button press, then wait until it shows in voted.
  task automatic pulse(input logic [2:0] y, input logic [2:0] n);
    yes_btn = y;
    no_btn  = n;
    tick(1);
    yes_btn = 3'b000;
    no_btn  = 3'b000;
    tick(2);
  endtask

  task automatic open_window();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [2:0] abc,
                           input logic valid, input logic dn,
                           input logic [2:0] vt, input logic bsy,
                           input logic [4:0] tl);
    check({tag, ".abc"},   32'({A, B, C}),     32'(abc));
    check({tag, ".valid"}, 32'(ballots_valid), 32'(valid));
    check({tag, ".done"},  32'(done),          32'(dn));
    check({tag, ".voted"}, 32'(voted),         32'(vt));
    check({tag, ".busy"},  32'(busy),          32'(bsy));
    check({tag, ".tl"},    32'(time_left),     32'(tl));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    yes_btn = 3'b000;
    no_btn  = 3'b000;
    tick(2);
    check_all("reset", 3'b000, 0, 0, 3'b000, 0, 5'd0);
    reset = 1'b0;
    tick(1);
    check_all("idle", 3'b000, 0, 0, 3'b000, 0, 5'd0);

    // 1: asynchronous reset in the middle of a window with A and B locked.
    open_window();
    check("t1_open_tl", 32'(time_left), 32'd16);
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b000);
    check_all("t1_pre", 3'b000, 0, 0, 3'b011, 1, 5'd10);
    #3 reset = 1'b1;
    #1;
    check_all("t1_async", 3'b000, 0, 0, 3'b000, 0, 5'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1);
    check_all("t1_idle", 3'b000, 0, 0, 3'b000, 0, 5'd0);

    // 2: all three vote -> early close, A,B,C = 1,1,0, res = 1.
    open_window();
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b000);
    check("t2_voted_ab", 32'(voted), 32'b011);
    pulse(3'b000, 3'b100);
    check_all("t2_close", 3'b110, 1, 1, 3'b111, 0, 5'd0);
    check("t2_res", 32'(A & (B | C)), 32'd1);
    tick(1);
    check("t2_done_once", 32'(done), 32'd0);
    check("t2_valid_held", 32'(ballots_valid), 32'd1);

    // 3: only B and C vote yes; window times out, chair veto gives res = 0.
    open_window();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t3_tl%0d", k), 32'(time_left), 32'(16 - k));
      if (k == 8) check("t3_voted", 32'(voted), 32'b110);
      yes_btn = (k == 0) ? 3'b010 : (k == 4) ? 3'b100 : 3'b000;
      tick(1);
    end
    check_all("t3_timeout", 3'b011, 1, 1, 3'b110, 0, 5'd0);
    check("t3_res", 32'(A & (B | C)), 32'd0);

    // 4: simultaneous yes/no on A ignored, then no locks A=0, later yes ignored.
    open_window();
    check_all("t4_open", 3'b000, 0, 0, 3'b000, 1, 5'd16);
    pulse(3'b001, 3'b001);
    check("t4_both_ignored", 32'(voted), 32'b000);
    pulse(3'b000, 3'b001);
    check("t4_no_locks", 32'(voted), 32'b001);
    pulse(3'b001, 3'b000);
    check("t4_late_yes_voted", 32'(voted), 32'b001);
    tick(7);
    check_all("t4_hold", 3'b000, 1, 1, 3'b001, 0, 5'd0);

    // 5: start during OPEN ignored; final vote on the time_left==1 cycle counts.
    open_window();
    yes_btn = 3'b011;
    tick(1);
    yes_btn = 3'b000;
    tick(4);
    check("t5_voted_ab", 32'(voted), 32'b011);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t5_start_ignored_tl", 32'(time_left), 32'd10);
    check("t5_start_ignored_busy", 32'(busy), 32'd1);
    tick(7);
    yes_btn = 3'b100;
    tick(1);
    yes_btn = 3'b000;
    tick(1);
    check("t5_last_tl", 32'(time_left), 32'd1);
    check("t5_last_voted", 32'(voted), 32'b011);
    tick(1);
    check_all("t5_expiry_vote", 3'b111, 1, 1, 3'b111, 0, 5'd0);

    // 6: start in HOLD reopens; a button held across the restart gives no edge.
    yes_btn = 3'b100;
    tick(4);
    open_window();
    check_all("t6_open", 3'b000, 0, 0, 3'b000, 1, 5'd16);
    tick(5);
    check("t6_held_no_edge", 32'(voted), 32'b000);
    yes_btn = 3'b000;
    tick(11);
    check_all("t6_hold", 3'b000, 1, 1, 3'b000, 0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_vote_collector
